// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: md_op command codes and helpers.
package md_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

  function automatic logic is_mult(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_if.sv
// Command/result bundle between the decode/execute stage and the multiply/divide unit.
// start is a valid with no ready: a command is taken only on an edge where busy is 0;
// a start seen while busy is dropped, and the pipeline relies on stall to never issue one.
interface md_if #(parameter int WIDTH = 32);
  import md_pkg::*;

  logic              start;
  logic [OP_W-1:0]   md_op;
  logic [WIDTH-1:0]  src_a;
  logic [WIDTH-1:0]  src_b;
  logic              md_use;
  logic              busy;
  logic              stall;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;

  modport master (
    output start, md_op, src_a, src_b, md_use,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, md_op, src_a, src_b, md_use,
    output busy, stall, hi, lo
  );

endinterface

// File: rtl/md_arith.sv
// Combinational result datapath: product or quotient/remainder of the captured operands.
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next,
  output logic             div_zero
);

  logic               sgn_mul;
  logic               sgn_div;
  logic [2*WIDTH-1:0] prod;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_div;
  logic [WIDTH-1:0]   uq;
  logic [WIDTH-1:0]   ur;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   r;

  assign sgn_mul = (op == MD_MULT);
  assign sgn_div = (op == MD_DIV);

  assign prod = {{WIDTH{sgn_mul & a[WIDTH-1]}}, a} * {{WIDTH{sgn_mul & b[WIDTH-1]}}, b};

  // Signed divide works on magnitudes; the overflow case -2^(W-1)/-1 falls out
  // naturally because the unsigned quotient 2^(W-1) re-reads as -2^(W-1).
  assign a_neg    = sgn_div & a[WIDTH-1];
  assign b_neg    = sgn_div & b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = is_div(op) && (b == '0);
  assign b_div    = div_zero ? WIDTH'(1) : b_mag;
  assign uq       = a_mag / b_div;
  assign ur       = a_mag % b_div;
  assign q        = (a_neg ^ b_neg) ? -uq : uq;
  assign r        = a_neg ? -ur : ur;

  always_comb begin
    hi_next = '0;
    lo_next = '0;
    if (is_mult(op)) begin
      hi_next = prod[2*WIDTH-1:WIDTH];
      lo_next = prod[WIDTH-1:0];
    end else if (is_div(op)) begin
      hi_next = r;
      lo_next = q;
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: latency counter, operand capture, HI/LO ownership and decode stall.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset_n,
  md_if.slave bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic             div_zero;
  logic             busy;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .hi_next  (hi_next),
    .lo_next  (lo_next),
    .div_zero (div_zero)
  );

  assign busy = (count != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= MD_MULT;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (busy) begin
      count <= count - CW'(1);
      // Result lands on the 1 -> 0 edge so it is visible the cycle busy drops.
      if (count == CW'(1) && !div_zero) begin
        hi_q <= hi_next;
        lo_q <= lo_next;
      end
    end else if (bus.start) begin
      case (bus.md_op)
        MD_MULT, MD_MULTU: begin
          a_q   <= bus.src_a;
          b_q   <= bus.src_b;
          op_q  <= bus.md_op;
          count <= CW'(MULT_CYCLES);
        end
        MD_DIV, MD_DIVU: begin
          a_q   <= bus.src_a;
          b_q   <= bus.src_b;
          op_q  <= bus.md_op;
          count <= CW'(DIV_CYCLES);
        end
        MD_MTHI: hi_q <= bus.src_a;
        MD_MTLO: lo_q <= bus.src_a;
        default: ;
      endcase
    end
  end

  assign bus.busy  = busy;
  assign bus.stall = bus.md_use & (bus.start | busy);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: table of arithmetic vectors plus hand-written pipeline sequences.
module tb_md_unit;
  import md_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset_n;

  md_if #(.WIDTH(W)) bus ();

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int           lat;
  } vec_t;

  vec_t vecs[9];
  int   errors = 0;
  int   checks = 0;

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  // drivers: inputs change on the falling edge, outputs are sampled #1 later
  task automatic drive(input logic st, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic use_);
    bus.start  = st;
    bus.md_op  = op;
    bus.src_a  = a;
    bus.src_b  = b;
    bus.md_use = use_;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Issue in cycle T, expect busy/stall for T+1..T+lat, result in T+lat+1.
  task automatic run_vec(input vec_t v);
    logic win_ok;
    @(negedge clk);
    drive(1'b1, v.op, v.a, v.b, 1'b1);
    #1 chk({v.name, " stall_T"}, W'(bus.stall), W'(1));
    @(posedge clk);
    #1 drive(1'b0, MD_MULT, '0, '0, 1'b1);
    win_ok = 1'b1;
    for (int k = 1; k <= v.lat; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.stall !== 1'b1) win_ok = 1'b0;
    end
    chk({v.name, " busy_window"}, W'(win_ok), W'(1));
    @(negedge clk);
    chk({v.name, " busy_end"}, W'(bus.busy), W'(0));
    chk({v.name, " hi"}, bus.hi, v.exp_hi);
    chk({v.name, " lo"}, bus.lo, v.exp_lo);
    drive(1'b0, MD_MULT, '0, '0, 1'b0);
  endtask

  task automatic mt_write(input logic [2:0] op, input logic [W-1:0] d);
    @(negedge clk);
    drive(1'b1, op, d, '0, 1'b0);
    @(negedge clk);
    drive(1'b0, MD_MULT, '0, '0, 1'b0);
  endtask

  initial begin : main
    logic ok;
    vec_t v;

    vecs[0] = '{"mult_neg1x2",  MD_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, MC};
    vecs[1] = '{"multu_big_x2", MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MC};
    vecs[2] = '{"div_m7_2",     MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[3] = '{"divu_7_2",     MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, DC};
    vecs[4] = '{"div_ovf",      MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
    vecs[5] = '{"mult_7_m3",    MD_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, MC};
    vecs[6] = '{"div_7_m2",     MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
    vecs[7] = '{"divu_max_16",  MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, DC};
    vecs[8] = '{"multu_2p16sq", MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MC};

    reset_n = 1'b0;
    drive(1'b0, MD_MULT, '0, '0, 1'b0);
    idle_cycles(3);
    #1;
    chk("reset_busy",  W'(bus.busy),  W'(0));
    chk("reset_stall", W'(bus.stall), W'(0));
    chk("reset_hi",    bus.hi, '0);
    chk("reset_lo",    bus.lo, '0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(2);

    foreach (vecs[i]) run_vec(vecs[i]);

    // mthi then mtlo on consecutive cycles
    @(negedge clk);
    drive(1'b1, MD_MTHI, 32'h12345678, '0, 1'b0);
    #1 chk("mt_stall_no_use", W'(bus.stall), W'(0));
    @(negedge clk);
    chk("mthi_hi",   bus.hi, 32'h12345678);
    chk("mthi_lo",   bus.lo, 32'h00000000);
    chk("mthi_busy", W'(bus.busy), W'(0));
    drive(1'b1, MD_MTLO, 32'h9ABCDEF0, '0, 1'b0);
    @(negedge clk);
    chk("mtlo_lo",   bus.lo, 32'h9ABCDEF0);
    chk("mtlo_hi",   bus.hi, 32'h12345678);
    chk("mtlo_busy", W'(bus.busy), W'(0));
    drive(1'b0, MD_MULT, '0, '0, 1'b0);

    // reserved opcode is ignored
    @(negedge clk);
    drive(1'b1, 3'd6, 32'hDEADBEEF, 32'h1, 1'b0);
    @(negedge clk);
    drive(1'b0, MD_MULT, '0, '0, 1'b0);
    chk("rsvd_busy", W'(bus.busy), W'(0));
    chk("rsvd_hi",   bus.hi, 32'h12345678);
    chk("rsvd_lo",   bus.lo, 32'h9ABCDEF0);

    // divide by zero keeps HI/LO but still takes the full latency
    mt_write(MD_MTHI, 32'hAAAA0000);
    mt_write(MD_MTLO, 32'h0000BBBB);
    v = '{"div_by_zero", MD_DIV, 32'h00001234, 32'h00000000, 32'hAAAA0000, 32'h0000BBBB, DC};
    run_vec(v);

    // start while busy is dropped; stall covers T..T+5; back-to-back start at T+6
    @(negedge clk);
    drive(1'b1, MD_MULT, 32'd3, 32'd4, 1'b1);
    ok = 1'b1;
    #1 if (bus.stall !== 1'b1) ok = 1'b0;
    @(posedge clk);
    #1 drive(1'b0, MD_MULT, '0, '0, 1'b1);
    for (int k = 1; k <= MC; k++) begin
      @(negedge clk);
      if (k == 2) drive(1'b1, MD_DIV, 32'd100, 32'd5, 1'b1);
      else        drive(1'b0, MD_MULT, '0, '0, 1'b1);
      #1 if (bus.stall !== 1'b1 || bus.busy !== 1'b1) ok = 1'b0;
    end
    chk("busy_start_stall", W'(ok), W'(1));
    @(negedge clk);
    chk("busy_start_hi",   bus.hi, 32'd0);
    chk("busy_start_lo",   bus.lo, 32'd12);
    chk("busy_start_idle", W'(bus.busy), W'(0));
    drive(1'b1, MD_MULTU, 32'd2, 32'd3, 1'b1);
    #1 chk("b2b_stall", W'(bus.stall), W'(1));
    @(negedge clk);
    drive(1'b0, MD_MULT, '0, '0, 1'b0);
    chk("b2b_accepted", W'(bus.busy), W'(1));
    idle_cycles(MC);
    chk("b2b_lo", bus.lo, 32'd6);
    chk("b2b_hi", bus.hi, 32'd0);

    // asynchronous reset in the middle of a divide cancels it
    mt_write(MD_MTHI, 32'h11111111);
    @(negedge clk);
    drive(1'b1, MD_DIVU, 32'd50, 32'd7, 1'b0);
    @(negedge clk);
    drive(1'b0, MD_MULT, '0, '0, 1'b0);
    idle_cycles(2);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", W'(bus.busy), W'(0));
    chk("arst_hi",   bus.hi, '0);
    chk("arst_lo",   bus.lo, '0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(DC + 2);
    chk("arst_no_write_hi", bus.hi, '0);
    chk("arst_no_write_lo", bus.lo, '0);
    v = '{"post_reset_mult", MD_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, MC};
    run_vec(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
